// File: rtl/score_controller_pkg.sv
// Shared score-keeping definitions: game state encodings and a saturating
// two-digit BCD adder reused by the scoring blocks.
package score_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Returns {tens, ones}; point nibbles above 9 count as 9 and the score sticks at 99.
    function automatic logic [7:0] bcd_add_sat(input logic [3:0] tens,
                                               input logic [3:0] ones,
                                               input logic [3:0] pts);
        logic [3:0] pts_c;
        logic [4:0] sum;
        logic [4:0] wrapped;
        logic [3:0] new_ones;
        logic       carry;
        pts_c   = (pts > BCD_MAX) ? BCD_MAX : pts;
        sum     = {1'b0, ones} + {1'b0, pts_c};
        wrapped = sum - 5'd10;
        if (sum > 5'd9) begin
            new_ones = wrapped[3:0];
            carry    = 1'b1;
        end else begin
            new_ones = sum[3:0];
            carry    = 1'b0;
        end
        if (carry && (tens >= BCD_MAX))
            bcd_add_sat = {BCD_MAX, BCD_MAX};
        else
            bcd_add_sat = {tens + {3'b000, carry}, new_ones};
    endfunction

endpackage

// File: rtl/score_controller_if.sv
// Hit bus between the game objects (master) and the score controller (slave).
interface score_controller_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   hit_req;
    logic [4*NUM_SRC-1:0] hit_pts;
    logic [NUM_SRC-1:0]   hit_ack;

    modport master (output hit_req, output hit_pts, input hit_ack);
    modport slave  (input hit_req, input hit_pts, output hit_ack);
endinterface

// File: rtl/score_controller_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer, which moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;

    // Search from the far end down so the candidate closest to ptr wins.
    always_comb begin
        grant     = '0;
        valid     = 1'b0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PW'((int'(ptr) + k) % N)]) begin
                valid     = 1'b1;
                grant_idx = PW'((int'(ptr) + k) % N);
            end
        end
        if (valid)
            grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance && valid)
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/score_controller.sv
// Game score/lives sequencer: arbitrates hit events into a shared BCD adder
// and runs the idle / play / death-delay / game-over sequence.
module score_controller
    import score_defs::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int START_LIVES  = 3,
    parameter int DEATH_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               miss,
    score_controller_if.slave  hit_bus,
    output logic [3:0]         score0,
    output logic [3:0]         score1,
    output logic [3:0]         lives,
    output logic [1:0]         state,
    output logic               serve
);
    game_state_t        cur_state;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] ack_q;
    logic               grant_valid;
    logic               playing;
    logic [7:0]         death_timer;
    logic [3:0]         grant_pts;
    logic [7:0]         next_score;

    assign playing          = (cur_state == ST_PLAYING);
    assign state            = cur_state;
    assign hit_bus.hit_ack  = ack_q;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (pending),
        .advance (playing),
        .grant   (grant),
        .valid   (grant_valid)
    );

    always_comb begin
        grant_pts = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (grant[i])
                grant_pts = hit_bus.hit_pts[4*i +: 4];
    end

    assign next_score = bcd_add_sat(score1, score0, grant_pts);

    // A grant in the miss cycle still scores; a new request in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            score0      <= 4'd0;
            score1      <= 4'd0;
            lives       <= 4'(START_LIVES);
            ack_q       <= '0;
            serve       <= 1'b0;
            pending     <= '0;
            death_timer <= 8'd0;
        end else begin
            ack_q <= '0;
            serve <= 1'b0;
            case (cur_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        cur_state <= ST_PLAYING;
                        score0    <= 4'd0;
                        score1    <= 4'd0;
                        lives     <= 4'(START_LIVES);
                        pending   <= '0;
                        serve     <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (grant_valid) begin
                        {score1, score0} <= next_score;
                        ack_q            <= grant;
                    end
                    if (miss) begin
                        cur_state   <= ST_DYING;
                        if (lives != 4'd0)
                            lives <= lives - 4'd1;
                        pending     <= '0;
                        death_timer <= 8'(DEATH_FRAMES);
                    end else begin
                        pending <= (pending & ~grant) | hit_bus.hit_req;
                    end
                end
                ST_DYING: begin
                    if (death_timer == 8'd0) begin
                        if (lives == 4'd0) begin
                            cur_state <= ST_GAME_OVER;
                        end else begin
                            cur_state <= ST_PLAYING;
                            serve     <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        death_timer <= death_timer - 8'd1;
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Sequences a game's scoring and lives state and drives the score0/score1/lives inputs of the scoreboard generator.
- Collects hit events from NUM_SRC game objects (bricks, targets, paddles) and arbitrates them round-robin into one shared BCD score adder, one grant per cycle.
- Handles ball-miss events and runs the attract / play / death-delay / game-over sequence, timed by frame ticks.
- Sits between the game-object logic and the scoreboard video generator.

Parameters:
- NUM_SRC, 4, number of hit requesters (1..8).
- START_LIVES, 3, lives loaded on reset and at game start (1..9).
- DEATH_FRAMES, 60, frame ticks spent in DYING before re-serve or game over (0..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start-game pulse (player button).
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived).
- hit_req  in  NUM_SRC  per-source hit pulse; bit i is source i.
- hit_pts  in  4*NUM_SRC  per-source BCD point value; nibble i belongs to source i.
- miss  in  1  ball-lost pulse.
- hit_ack  out  NUM_SRC  one-hot, one-cycle grant pulse when a source's points are applied.
- score0  out  4  BCD ones digit.
- score1  out  4  BCD tens digit.
- lives  out  4  remaining lives, 0..9.
- state  out  2  0=IDLE, 1=PLAYING, 2=DYING, 3=GAME_OVER.
- serve  out  1  one-cycle pulse: launch a new ball.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, score0=0, score1=0, lives=START_LIVES.
  - hit_ack=0, serve=0, pending=0.
  - Round-robin pointer=0, death timer=0.
- Pending latch:
  - In PLAYING, hit_req[i]=1 sets pending[i].
  - A grant to source i clears pending[i].
  - If a set and a clear hit the same source in one cycle, the set wins and pending[i] stays 1.
  - In any other state, hit_req is ignored and not latched.
- Arbiter:
  - Each PLAYING cycle, grant the first pending source at or after the pointer, searching upward with wrap.
  - After a grant to source g, the pointer becomes (g+1) mod NUM_SRC.
  - At most one grant per cycle. hit_ack[g] pulses in the same cycle the score registers update, one cycle after the grant decision.
  - Hit-to-score latency is 2 cycles at minimum: cycle 1 latches pending, cycle 2 applies points and asserts hit_ack.
- BCD add:
  - A point nibble above 9 is clamped to 9.
  - sum = score0 + pts. If sum > 9, score0 = sum - 10 and carry into score1.
  - Saturation: if score1 would exceed 9, the score saturates at 99 (both digits 9). It never wraps.
- FSM transitions:
  - IDLE / GAME_OVER, start=1 → PLAYING. Same edge: score cleared to 00, lives=START_LIVES, pending cleared, serve pulses next cycle.
  - PLAYING, miss=1 → DYING. Same edge: if lives != 0, lives decrements. Pending cleared, timer=DEATH_FRAMES.
  - A grant issued in the same cycle as the miss is still applied and acked.
  - DYING: the timer decrements on each frame_tick while nonzero.
  - DYING, timer==0 → GAME_OVER if lives==0; otherwise → PLAYING with a serve pulse.
  - DEATH_FRAMES=0 leaves DYING on the cycle after entry.
- Ignored inputs:
  - start is ignored in PLAYING and DYING.
  - miss is ignored outside PLAYING.
  - frame_tick only affects DYING.
- Reset mid-operation: returns to IDLE with all reset values. Any in-flight grant is discarded and no ack is emitted.
- Outputs are registered, with no combinational path from input to output.

Decomposition:
- Shared package (score_defs): state encodings ST_IDLE/ST_PLAYING/ST_DYING/ST_GAME_OVER and a bcd_add_sat function (two digits plus a nibble → two digits, clamp and saturate). The package is reused by other score-keeping blocks.
- One sub-module, rr_arbiter: parameter N; inputs clk, reset, req[N], advance; outputs grant[N] one-hot and valid.

Test Plan:
1. reset, then start pulse → state=1, score=00, lives=3, serve pulses once; then one hit_req[0] with pts=5 → 2 cycles later score0=5, hit_ack[0] pulses.
2. Score 07, then hit with pts=5 → score1=1, score0=2. Score 97, then hit pts=9 → score 99; a further hit pts=1 stays 99. A pts nibble of 0xC is applied as 9.
3. From pointer=0, hit_req=4'b1111 in one cycle → hit_ack order 0,1,2,3 on consecutive cycles. Then a new request on sources 1 and 3 → order 1,3.
4. miss in PLAYING with lives=3 → state=2, lives=2. After 60 frame_ticks → state=1 and serve pulses. hit_req during DYING → no ack.
5. Three misses with DEATH_FRAMES elapsed → lives=0, state=3 (GAME_OVER). start → lives=3, score=00, state=1.
6. Pending on sources 1 and 2 plus reset asserted → next cycle state=0, no hit_ack, score=00, lives=3. Also: miss and a grant in the same cycle → points applied and lives decremented.
